// File: rtl/spi_frame_receiver.sv
`default_nettype none
// ============================================================================
// spi_frame_receiver
//   SPI (mode 0, MSB first) pixel deserialiser for a double-buffered frame
//   memory, with idle-timeout resynchronisation of partial pixels and frames.
//   Revision: 1.0
// ============================================================================
module spi_frame_receiver #(
    parameter int BITS_PER_PIXEL = 16,
    parameter int PIXELS         = 2048,
    parameter int IDLE_TIMEOUT   = 4096
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      spi_clk,
    input  logic                      spi_mosi,
    output logic                      wr_en,
    output logic [$clog2(PIXELS):0]   wr_addr,
    output logic [BITS_PER_PIXEL-1:0] wr_data,
    output logic                      display_buffer,
    output logic                      frame_done,
    output logic                      resync,
    output logic [7:0]                frame_count
);
    localparam int AW  = $clog2(PIXELS);
    localparam int BCW = $clog2(BITS_PER_PIXEL);
    localparam int IW  = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [AW-1:0]  LAST_PIXEL = AW'(PIXELS - 1);
    localparam logic [BCW-1:0] LAST_BIT   = BCW'(BITS_PER_PIXEL - 1);
    localparam logic [IW-1:0]  IDLE_MAX   = IW'(IDLE_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RECEIVING = 2'd1,
        ST_COMMIT    = 2'd2
    } state_t;

    // spi_clk and spi_mosi share synchroniser depth so the sampled bit aligns
    // with the detected edge.
    logic [1:0] sclk_sync_q;
    logic [1:0] mosi_sync_q;
    logic       sclk_hist_q;

    state_t                    state_q, state_d;
    logic [BITS_PER_PIXEL-1:0] shift_q, shift_d;
    logic [BCW-1:0]            bit_count_q, bit_count_d;
    logic [AW-1:0]             pixel_index_q, pixel_index_d;
    logic [IW-1:0]             idle_q, idle_d;
    logic                      write_buffer_q, write_buffer_d;
    logic [7:0]                frame_count_q, frame_count_d;
    logic                      wr_en_q, wr_en_d;
    logic [AW:0]               wr_addr_q, wr_addr_d;
    logic [BITS_PER_PIXEL-1:0] wr_data_q, wr_data_d;
    logic                      frame_done_q, frame_done_d;
    logic                      resync_q, resync_d;

    logic sclk_rise;
    logic sclk_edge;
    logic timeout;

    assign sclk_rise = sclk_sync_q[1] & ~sclk_hist_q;
    assign sclk_edge = sclk_sync_q[1] ^ sclk_hist_q;
    assign timeout   = (idle_q == IDLE_MAX) && !sclk_edge;

    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        bit_count_d    = bit_count_q;
        pixel_index_d  = pixel_index_q;
        write_buffer_d = write_buffer_q;
        frame_count_d  = frame_count_q;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        frame_done_d   = 1'b0;
        resync_d       = 1'b0;

        if (sclk_edge) begin
            idle_d = '0;
        end else if (idle_q == IDLE_MAX) begin
            idle_d = idle_q;
        end else begin
            idle_d = idle_q + IW'(1);
        end

        // Buffer swap lags frame_done by one cycle so the last pixel of a
        // frame lands in the buffer it belongs to.
        if (frame_done_q) begin
            write_buffer_d = ~write_buffer_q;
            frame_count_d  = frame_count_q + 8'd1;
        end

        if (state_q == ST_COMMIT) begin
            wr_en_d   = 1'b1;
            wr_data_d = shift_q;
            wr_addr_d = {write_buffer_q, pixel_index_q};
            if (pixel_index_q == LAST_PIXEL) begin
                frame_done_d  = 1'b1;
                pixel_index_d = '0;
                state_d       = ST_IDLE;
            end else begin
                pixel_index_d = pixel_index_q + AW'(1);
                state_d       = ST_RECEIVING;
            end
        end

        if (sclk_rise) begin
            shift_d = {shift_q[BITS_PER_PIXEL-2:0], mosi_sync_q[1]};
            if (bit_count_q == LAST_BIT) begin
                bit_count_d = '0;
                state_d     = ST_COMMIT;
            end else begin
                bit_count_d = bit_count_q + BCW'(1);
                state_d     = ST_RECEIVING;
            end
        end else if (timeout && state_q != ST_COMMIT &&
                     (bit_count_q != '0 || pixel_index_q != '0)) begin
            shift_d       = '0;
            bit_count_d   = '0;
            pixel_index_d = '0;
            resync_d      = 1'b1;
            state_d       = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q    <= '0;
            mosi_sync_q    <= '0;
            sclk_hist_q    <= 1'b0;
            state_q        <= ST_IDLE;
            shift_q        <= '0;
            bit_count_q    <= '0;
            pixel_index_q  <= '0;
            idle_q         <= '0;
            write_buffer_q <= 1'b0;
            frame_count_q  <= '0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            frame_done_q   <= 1'b0;
            resync_q       <= 1'b0;
        end else begin
            sclk_sync_q    <= {sclk_sync_q[0], spi_clk};
            mosi_sync_q    <= {mosi_sync_q[0], spi_mosi};
            sclk_hist_q    <= sclk_sync_q[1];
            state_q        <= state_d;
            shift_q        <= shift_d;
            bit_count_q    <= bit_count_d;
            pixel_index_q  <= pixel_index_d;
            idle_q         <= idle_d;
            write_buffer_q <= write_buffer_d;
            frame_count_q  <= frame_count_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            frame_done_q   <= frame_done_d;
            resync_q       <= resync_d;
        end
    end

    assign wr_en          = wr_en_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign display_buffer = ~write_buffer_q;
    assign frame_done     = frame_done_q;
    assign resync         = resync_q;
    assign frame_count    = frame_count_q;

endmodule
`default_nettype wire
